univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the single-bit posedge D flip-flop with active-low clear. It adds a WIDTH-bit register, hold, shift, load, rotate and sync-clear modes, serial in/out, and a shift counter with a completion pulse. It sits in serialisers, deserialisers and bit-manipulation datapaths inside the sequential-circuit library.

Parameters:
WIDTH, 8, register width in bits (>=2)
RST_VAL, {WIDTH{1'b0}}, value loaded into q on asynchronous reset
CW, $clog2(WIDTH+1), counter width (derived localparam, not overridable)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  asynchronous active-low reset
en  input  1  operation enable; when low, all state holds
mode  input  3  operation select (encoding below)
d  input  WIDTH  parallel load data
sin_msb  input  1  serial bit entering the MSB on a right shift
sin_lsb  input  1  serial bit entering the LSB on a left shift
q  output  WIDTH  register contents
sout_r  output  1  equals q[0]
sout_l  output  1  equals q[WIDTH-1]
cnt  output  CW  shifts/rotates since the last load or clear, saturating at WIDTH
done  output  1  one-cycle pulse when cnt reaches WIDTH

Behaviour:
- Reset: clock is one clk; reset is asynchronous and active-low on rst. When rst is low, immediately q=RST_VAL, cnt=0, done=0, regardless of clk. Reset mid-shift aborts the operation with no residue.
- All updates occur on posedge clk when rst is high and en is high. If en is low, q and cnt hold and done=0.
- Mode encoding (en=1):
  - 000 hold: q holds, cnt holds.
  - 001 shift right: q <= {sin_msb, q[WIDTH-1:1]}.
  - 010 shift left: q <= {q[WIDTH-2:0], sin_lsb}.
  - 011 load: q <= d; cnt <= 0.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}.
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 sync clear: q <= 0 (not RST_VAL); cnt <= 0.
  - 111 reserved: behaves exactly as hold.
- Latency: q reflects the operation one cycle after the sampling edge. sout_r and sout_l are combinational from q.
- Counter: modes 001, 010, 100 and 101 increment cnt by 1, saturating at WIDTH. Once saturated, cnt stays at WIDTH and the shift itself still executes.
- done: registered. It is 1 for exactly the one cycle following the edge at which cnt transitions WIDTH-1 -> WIDTH; it is 0 otherwise. Further shifts while saturated do not re-pulse done.
- Load or clear on the same edge that would saturate the counter: load/clear wins, cnt=0, done=0.
- Mode changes between any two cycles are legal, with no bubbles.

Optional Feature:
USR_ROTATE_EN
- Defined: modes 100 and 101 rotate as specified and count toward cnt/done.
- Undefined: modes 100 and 101 behave as hold. cnt is unaffected and no rotate logic is synthesised.

Decomposition:
- Package usr_pkg holds:
  - mode localparams: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_CLR, MODE_RSVD, all 3-bit;
  - the function is_shift(mode), which returns 1 for the counting modes and honours USR_ROTATE_EN.
- One sub-module, usr_shift_cnt: saturating counter plus done pulse generator, with inputs clk, rst, en, inc, clr.

Test Plan (WIDTH=8, RST_VAL=8'hA5):
1. rst low mid-cycle with clk idle -> q=8'hA5, cnt=0 and done=0 asynchronously; they hold after rst is released with en=0.
2. load d=8'h81, then 8x shift right with sin_msb=0 -> sout_r sequence 1,0,0,0,0,0,0,1. Final q=8'h00, cnt=8, done high for 1 cycle after the 8th shift only.
3. load 8'h01, shift left with sin_lsb=1 x3 -> q=8'h0F, cnt=3. A further 9 shifts keep cnt=8 with a single done pulse.
4. With USR_ROTATE_EN: load 8'h96, rotate left x8 -> q returns to 8'h96, done pulses once. Without it: same stimulus -> q stays 8'h96, cnt=0, no done.
5. load 8'hFF, hold with en=0 for 4 cycles while mode=001 -> q=8'hFF, cnt=0. Then mode=110 -> q=8'h00 (not 8'hA5), cnt=0.
6. 7 shifts, then load on the 8th cycle -> cnt=0, no done pulse. mode=111 for 3 cycles -> q unchanged.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg : shared definitions for the universal shift register.
//
// Contents
//   MODE_*     3-bit operation codes driven on the mode input
//   is_shift() 1 for the modes that advance the shift counter
//
// Configuration macro: USR_ROTATE_EN
//   defined   -> rotate modes (MODE_ROR / MODE_ROL) count as shifts
//   undefined -> rotate modes are treated as hold and never count
// -----------------------------------------------------------------------------
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  // Modes that move bits through the register and therefore advance cnt.
  function automatic logic is_shift(input logic [2:0] mode);
    logic res;
    res = 1'b0;
    case (mode)
      MODE_SHR, MODE_SHL: res = 1'b1;
`ifdef USR_ROTATE_EN
      MODE_ROR, MODE_ROL: res = 1'b1;
`endif
      default:            res = 1'b0;
    endcase
    return res;
  endfunction

  // Modes that restart the shift count (and suppress a pending done pulse).
  function automatic logic is_restart(input logic [2:0] mode);
    return (mode == MODE_LOAD) || (mode == MODE_CLR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_if : control/data bundle of the universal shift register.
//
// Handshake: there is no valid/ready pair. The register samples en, mode, d,
// sin_msb and sin_lsb on every rising clock edge; en=1 means "perform mode
// this cycle", en=0 means "hold everything". Results (q, cnt, done) appear one
// cycle after the sampling edge; sout_r/sout_l follow q combinationally.
//
// Signals
//   en       operation enable            (master -> slave)
//   mode     operation select, 3 bits    (master -> slave)
//   d        parallel load data, WIDTH   (master -> slave)
//   sin_msb  serial in for right shift   (master -> slave)
//   sin_lsb  serial in for left shift    (master -> slave)
//   q        register contents, WIDTH    (slave -> master)
//   sout_r   q[0]                        (slave -> master)
//   sout_l   q[WIDTH-1]                  (slave -> master)
//   cnt      shifts since load/clear, CW (slave -> master)
//   done     one-cycle saturation pulse  (slave -> master)
//
// Modports: master (drives controls), slave (the register).
// -----------------------------------------------------------------------------
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_msb;
  logic             sin_lsb;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             done;

  modport master (
    output en, mode, d, sin_msb, sin_lsb,
    input  q, sout_r, sout_l, cnt, done
  );

  modport slave (
    input  en, mode, d, sin_msb, sin_lsb,
    output q, sout_r, sout_l, cnt, done
  );
endinterface

// File: rtl/univ_shift_reg_shift_cnt.sv
// -----------------------------------------------------------------------------
// usr_shift_cnt : saturating shift counter with a registered completion pulse.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-low reset (cnt=0, done=0)
//   en    enable; when low the count holds and done drops
//   inc   this cycle's operation is a counting shift
//   clr   this cycle's operation is a load/clear (restart)
//   cnt   count, saturates at WIDTH
//   done  1 for the cycle after cnt steps WIDTH-1 -> WIDTH
// -----------------------------------------------------------------------------
module usr_shift_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] CNT_SAT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      // Restart takes priority over a shift that would saturate this edge.
      if (clr) begin
        cnt_d = '0;
      end else if (inc && (cnt_q != CNT_SAT)) begin
        cnt_d  = cnt_q + CW'(1);
        // Pulse only on the transition into saturation, never while parked.
        done_d = (cnt_q == CNT_PRE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg : WIDTH-bit universal shift register.
//
// Operations (selected by bus.mode when bus.en=1): hold, shift right/left with
// serial input, parallel load, rotate right/left, synchronous clear, reserved
// (= hold). A shift counter reports shifts since the last load/clear and
// pulses done once when it reaches WIDTH.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-low reset: q=RST_VAL, cnt=0, done=0
//   bus   univ_shift_reg_if.slave (en, mode, d, sin_msb, sin_lsb in;
//         q, sout_r, sout_l, cnt, done out)
//
// Configuration macro: USR_ROTATE_EN
//   defined   -> modes 100/101 rotate and count
//   undefined -> modes 100/101 hold; no rotate datapath is built
// -----------------------------------------------------------------------------
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  univ_shift_reg_if.slave      bus
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2) begin : g_width_check
    $error("univ_shift_reg: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             cnt_inc;
  logic             cnt_clr;
  logic [CW-1:0]    cnt_w;
  logic             done_w;

  // Next register value. Anything not listed (hold, reserved, and rotates
  // when the rotate option is absent) keeps q.
  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      case (bus.mode)
        MODE_SHR:  q_d = {bus.sin_msb, q_q[WIDTH-1:1]};
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], bus.sin_lsb};
        MODE_LOAD: q_d = bus.d;
`ifdef USR_ROTATE_EN
        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`endif
        // Sync clear goes to all-zero, deliberately not RST_VAL.
        MODE_CLR:  q_d = '0;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // The counter applies en itself; these only classify the current mode.
  assign cnt_inc = is_shift(bus.mode);
  assign cnt_clr = is_restart(bus.mode);

  usr_shift_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shift_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .cnt  (cnt_w),
    .done (done_w)
  );

  assign bus.q      = q_q;
  assign bus.sout_r = q_q[0];
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.cnt    = cnt_w;
  assign bus.done   = done_w;

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg : self-checking bench for univ_shift_reg (WIDTH=8,
// RST_VAL=8'hA5). Directed scenarios followed by randomized traffic, all
// checked against an arithmetic reference model of the register.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int         W       = 8;
  localparam logic [7:0] RST_VAL = 8'hA5;
`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic clk_run = 1'b1;
  logic rst     = 1'b0;

  always #5 if (clk_run) clk = ~clk;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(
    .WIDTH   (W),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  int m_q;
  int m_cnt;
  bit m_done;

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;
  int done_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q    = int'(RST_VAL);
    m_cnt  = 0;
    m_done = 1'b0;
  endtask

  // One clock edge of the behavioural model, written from the mode table.
  task automatic model_edge(input bit e, input int m, input int dv, input bit smsb, input bit slsb);
    bit shifting;
    shifting = 1'b0;
    if (!e) begin
      m_done = 1'b0;
      return;
    end
    case (m)
      1: begin m_q = (m_q >> 1) | (smsb ? 128 : 0);  shifting = 1'b1; end
      2: begin m_q = ((m_q * 2) % 256) + (slsb ? 1 : 0); shifting = 1'b1; end
      3: begin m_q = dv; m_cnt = 0; end
      4: if (ROT) begin m_q = (m_q >> 1) + ((m_q % 2) * 128); shifting = 1'b1; end
      5: if (ROT) begin m_q = ((m_q * 2) % 256) + (m_q / 128); shifting = 1'b1; end
      6: begin m_q = 0; m_cnt = 0; end
      default: ;
    endcase
    if (shifting) begin
      m_done = (m_cnt == W - 1);
      if (m_cnt < W) m_cnt++;
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},      32'(bus.q),      32'(m_q));
    chk({tag, ".cnt"},    32'(bus.cnt),    32'(m_cnt));
    chk({tag, ".done"},   32'(bus.done),   32'(m_done));
    chk({tag, ".sout_r"}, 32'(bus.sout_r), 32'(m_q % 2));
    chk({tag, ".sout_l"}, 32'(bus.sout_l), 32'(m_q / 128));
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input bit e, input logic [2:0] m,
                      input logic [7:0] dv, input bit smsb, input bit slsb);
    bus.en      = e;
    bus.mode    = m;
    bus.d       = dv;
    bus.sin_msb = smsb;
    bus.sin_lsb = slsb;
    @(posedge clk);
    model_edge(e, int'(m), int'(dv), smsb, slsb);
    #1;
    check_all(tag);
    if (bus.done === 1'b1) done_seen++;
  endtask

  // Reset pulse between edges while the clock keeps running.
  task automatic mid_cycle_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int q_before;
    bus.en = 1'b0; bus.mode = 3'b000; bus.d = '0; bus.sin_msb = 1'b0; bus.sin_lsb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1. asynchronous reset with the clock stopped, then hold with en=0
    step("t1_load", 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    clk_run = 1'b0;
    #7 rst = 1'b0;
    #1;
    model_reset();
    chk("t1_async_q",    32'(bus.q),    32'h0000_00A5);
    chk("t1_async_cnt",  32'(bus.cnt),  32'd0);
    chk("t1_async_done", 32'(bus.done), 32'd0);
    #3 rst = 1'b1;
    clk_run = 1'b1;
    step("t1_hold0", 1'b0, 3'b001, 8'h00, 1'b1, 1'b1);
    step("t1_hold1", 1'b0, 3'b011, 8'hFF, 1'b1, 1'b1);

    // 2. load 81, eight right shifts
    step("t2_load", 1'b1, 3'b011, 8'h81, 1'b0, 1'b0);
    chk("t2_sout_r_first", 32'(bus.sout_r), 32'd1);
    done_seen = 0;
    for (int i = 0; i < 8; i++) step("t2_shr", 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    chk("t2_final_q",   32'(bus.q),   32'h0);
    chk("t2_final_cnt", 32'(bus.cnt), 32'd8);
    chk("t2_done_high", 32'(bus.done), 32'd1);
    step("t2_after", 1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    chk("t2_done_pulses", 32'(done_seen), 32'd1);

    // 3. left shifts, then saturation with a single done pulse
    step("t3_load", 1'b1, 3'b011, 8'h01, 1'b0, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) step("t3_shl", 1'b1, 3'b010, 8'h00, 1'b0, 1'b1);
    chk("t3_q",   32'(bus.q),   32'h0F);
    chk("t3_cnt", 32'(bus.cnt), 32'd3);
    for (int i = 0; i < 9; i++) step("t3_shl_sat", 1'b1, 3'b010, 8'h00, 1'b0, 1'b1);
    chk("t3_cnt_sat", 32'(bus.cnt), 32'd8);
    chk("t3_done_pulses", 32'(done_seen), 32'd1);

    // 4. rotate left x8 (hold when rotate is not built)
    step("t4_load", 1'b1, 3'b011, 8'h96, 1'b0, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) step("t4_rol", 1'b1, 3'b101, 8'h00, 1'b1, 1'b1);
    step("t4_after", 1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    chk("t4_q",   32'(bus.q),   32'h96);
    chk("t4_cnt", 32'(bus.cnt), ROT ? 32'd8 : 32'd0);
    chk("t4_done_pulses", 32'(done_seen), ROT ? 32'd1 : 32'd0);

    // 5. en=0 hold with a shift mode presented, then sync clear
    step("t5_load", 1'b1, 3'b011, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("t5_en0", 1'b0, 3'b001, 8'h00, 1'b0, 1'b0);
    chk("t5_q",   32'(bus.q),   32'hFF);
    chk("t5_cnt", 32'(bus.cnt), 32'd0);
    step("t5_clr", 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    chk("t5_clr_q",   32'(bus.q),   32'h00);
    chk("t5_clr_cnt", 32'(bus.cnt), 32'd0);

    // 6. load on the edge that would saturate, then reserved mode
    step("t6_load", 1'b1, 3'b011, 8'h5A, 1'b0, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 7; i++) step("t6_shr", 1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
    step("t6_load8", 1'b1, 3'b011, 8'hC3, 1'b0, 1'b0);
    step("t6_after", 1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    chk("t6_cnt", 32'(bus.cnt), 32'd0);
    chk("t6_done_pulses", 32'(done_seen), 32'd0);
    q_before = m_q;
    for (int i = 0; i < 3; i++) step("t6_rsvd", 1'b1, 3'b111, 8'hFF, 1'b1, 1'b1);
    chk("t6_rsvd_q", 32'(bus.q), 32'(q_before));

    // Random traffic, biased toward shifting so the counter saturates often.
    for (int i = 0; i < 400; i++) begin
      bit          e;
      logic [2:0]  m;
      e = ($urandom_range(0, 9) != 0);
      m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                      : 3'($urandom_range(1, 2));
      if ($urandom_range(0, 15) == 0) m = 3'b011;
      step("rnd", e, m, 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 59) == 0) mid_cycle_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
